// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: mode codes, FSM states, shift-mode classifier.
// UNIV_SHIFT_REG_ASR_EN makes code 7 an arithmetic shift right that is also legal in bursts.
package univ_shift_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_CLR  = 3'd6
    } mode_e;

    localparam logic [MODE_W-1:0] MODE_ASR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only these codes may drive a burst; everything else finishes immediately.
    function automatic logic is_shift(input logic [MODE_W-1:0] m);
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: return 1'b1;
`ifdef UNIV_SHIFT_REG_ASR_EN
            MODE_ASR: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/univ_shift_reg_core.sv
// Combinational next-value / serial-out datapath for one register operation.
// UNIV_SHIFT_REG_ASR_EN adds the arithmetic shift right on code 7; otherwise code 7 holds.
module univ_shift_reg_core
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  out_i,
    input  logic [WIDTH-1:0]  in_i,
    input  logic              sin_i,
    output logic [WIDTH-1:0]  nxt_o,
    output logic              sout_o,
    output logic              sout_upd_o
);

    always_comb begin
        nxt_o      = out_i;
        sout_o     = 1'b0;
        sout_upd_o = 1'b0;
        case (mode_i)
            MODE_LOAD: nxt_o = in_i;
            MODE_CLR:  nxt_o = '0;
            MODE_SHL: begin
                nxt_o      = {out_i[WIDTH-2:0], sin_i};
                sout_o     = out_i[WIDTH-1];
                sout_upd_o = 1'b1;
            end
            MODE_SHR: begin
                nxt_o      = {sin_i, out_i[WIDTH-1:1]};
                sout_o     = out_i[0];
                sout_upd_o = 1'b1;
            end
            MODE_ROL: begin
                nxt_o      = {out_i[WIDTH-2:0], out_i[WIDTH-1]};
                sout_o     = out_i[WIDTH-1];
                sout_upd_o = 1'b1;
            end
            MODE_ROR: begin
                nxt_o      = {out_i[0], out_i[WIDTH-1:1]};
                sout_o     = out_i[0];
                sout_upd_o = 1'b1;
            end
`ifdef UNIV_SHIFT_REG_ASR_EN
            MODE_ASR: begin
                nxt_o      = {out_i[WIDTH-1], out_i[WIDTH-1:1]};
                sout_o     = out_i[0];
                sout_upd_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a counted burst engine (IDLE -> BUSY -> DONE).
// Define UNIV_SHIFT_REG_ASR_EN to enable arithmetic shift right on mode code 7.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  in,
    input  logic              sin,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic [WIDTH-1:0]  out,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    out_q;
    logic                sout_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [MODE_W-1:0]   core_mode;
    logic [CNT_W-1:0]    burst_len;
    logic [WIDTH-1:0]    core_nxt;
    logic                core_sout;
    logic                core_sout_upd;

    assign burst_len = (count > WIDTH_C) ? WIDTH_C : count;

    // cnt_q holds the shifts still owed after the current BUSY cycle; the start
    // edge already performed the first one, so BUSY lasts exactly burst_len cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        core_mode = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift(mode) && (count != '0)) begin
                        core_mode = mode;
                        mode_d    = mode;
                        cnt_d     = burst_len - ONE_C;
                        state_d   = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    core_mode = mode;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    core_mode = mode_q;
                    cnt_d     = cnt_q - ONE_C;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    univ_shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .mode_i     (core_mode),
        .out_i      (out_q),
        .in_i       (in),
        .sin_i      (sin),
        .nxt_o      (core_nxt),
        .sout_o     (core_sout),
        .sout_upd_o (core_sout_upd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
        end else begin
            state_q <= state_d;
            out_q   <= core_nxt;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            if (core_sout_upd) begin
                sout_q <= core_sout;
            end
        end
    end

    assign out  = out_q;
    assign sout = sout_q;
    assign busy = (state_q == ST_BUSY);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed spec vectors plus random ops and bursts.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic [2:0] mode;
    logic [7:0] in_v;
    logic       sin;
    logic       start;
    logic [3:0] count;
    logic [7:0] out;
    logic       sout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and last bit shifted out
    logic [7:0] m_out  = 8'h00;
    logic       m_sout = 1'b0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .in    (in_v),
        .sin   (sin),
        .start (start),
        .count (count),
        .out   (out),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_shift_m(input int m);
`ifdef UNIV_SHIFT_REG_ASR_EN
        return (m >= 2 && m <= 5) || (m == 7);
`else
        return (m >= 2 && m <= 5);
`endif
    endfunction

    task automatic model_apply(input int m, input bit s, input logic [7:0] d);
        case (m)
            1: m_out = d;
            2: begin m_sout = m_out[7]; m_out = (m_out << 1) | {7'd0, s};             end
            3: begin m_sout = m_out[0]; m_out = (m_out >> 1) | (s ? 8'h80 : 8'h00);   end
            4: begin m_sout = m_out[7]; m_out = (m_out << 1) | (m_out >> 7);          end
            5: begin m_sout = m_out[0]; m_out = (m_out >> 1) | (m_out << 7);          end
            6: m_out = 8'h00;
`ifdef UNIV_SHIFT_REG_ASR_EN
            7: begin m_sout = m_out[0]; m_out = $signed(m_out) >>> 1;                end
`endif
            default: ;
        endcase
    endtask

    task automatic op(input int m, input logic [7:0] d, input bit s);
        mode  = m[2:0];
        in_v  = d;
        sin   = s;
        start = 1'b0;
        tick();
        model_apply(m, s, d);
        chk("op_out", out, m_out);
        chk("op_sout", sout, m_sout);
        chk("op_busy", busy, 1'b0);
        chk("op_done", done, 1'b0);
    endtask

    // Burst of min(cnt,8) shifts; sin random unless rand_sin=0 (then held low).
    task automatic run_burst(input int m, input int cnt, input bit rand_sin);
        int n;
        int shifts;
        bit s;
        logic [7:0] held;
        n      = (cnt > 8) ? 8 : cnt;
        s      = rand_sin ? 1'($urandom) : 1'b0;
        mode   = m[2:0];
        count  = cnt[3:0];
        in_v   = 8'($urandom);
        sin    = s;
        start  = 1'b1;
        tick();
        if (!is_shift_m(m) || n == 0) begin
            chk("nb_busy", busy, 1'b0);
            chk("nb_done", done, 1'b1);
            chk("nb_out", out, m_out);
            chk("nb_sout", sout, m_sout);
        end else begin
            model_apply(m, s, in_v);
            shifts = 1;
            for (int k = 0; k < n; k++) begin
                chk("bu_busy", busy, 1'b1);
                chk("bu_done", done, 1'b0);
                chk("bu_out", out, m_out);
                chk("bu_sout", sout, m_sout);
                s     = rand_sin ? 1'($urandom) : 1'b0;
                sin   = s;
                mode  = 3'($urandom);
                in_v  = 8'($urandom);
                start = 1'($urandom);
                count = 4'($urandom);
                tick();
                if (shifts < n) begin
                    model_apply(m, s, in_v);
                    shifts++;
                end
            end
            chk("bu_end_busy", busy, 1'b0);
            chk("bu_end_done", done, 1'b1);
            chk("bu_end_out", out, m_out);
            chk("bu_end_sout", sout, m_sout);
        end
        // A start presented during DONE must be ignored
        held  = m_out;
        mode  = 3'd2;
        count = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 3'd0;
        chk("dn_busy", busy, 1'b0);
        chk("dn_done", done, 1'b0);
        chk("dn_out", out, held);
    endtask

    initial begin
        rst   = 1'b1;
        mode  = 3'd0;
        in_v  = 8'h00;
        sin   = 1'b0;
        start = 1'b0;
        count = 4'd0;
        #2 rst = 1'b0;
        #2;
        chk("rst_out", out, 8'h00);
        chk("rst_sout", sout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        tick();
        tick();
        rst = 1'b1;

        // LOAD then single ROL
        op(1, 8'hA5, 1'b0);
        chk("load_a5", out, 8'hA5);
        op(4, 8'h00, 1'b0);
        chk("rol_out", out, 8'h4B);
        chk("rol_sout", sout, 1'b1);

        // SHR burst of 3 from 0x81 with sin low
        op(1, 8'h81, 1'b0);
        run_burst(3, 3, 1'b0);
        chk("shr3_out", out, 8'h10);
        chk("shr3_sout", sout, 1'b0);

        // ROL burst clamped to 8 shifts, immediately back-to-back
        op(1, 8'h01, 1'b0);
        run_burst(4, 15, 1'b1);
        chk("rol15_out", out, 8'h01);
        run_burst(5, 2, 1'b1);

        // count=0 and a non-shift mode both complete without busy
        op(1, 8'h3C, 1'b0);
        run_burst(2, 0, 1'b1);
        chk("cnt0_out", out, 8'h3C);
        run_burst(1, 5, 1'b1);
        chk("load_burst_out", out, 8'h3C);

        // CLR and HOLD leave sout alone
        op(2, 8'h00, 1'b1);
        op(6, 8'hFF, 1'b0);
        op(0, 8'hFF, 1'b1);

        // Reset two shifts into an SHL burst of 6
        op(1, 8'hF3, 1'b0);
        mode  = 3'd2;
        count = 4'd6;
        sin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_out", out, 8'h00);
        chk("abort_sout", sout, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_hold_done", done, 1'b0);
        end
        rst    = 1'b1;
        m_out  = 8'h00;
        m_sout = 1'b0;
        op(0, 8'h00, 1'b0);
        chk("after_abort_out", out, 8'h00);

        // Mode 7: ASR when enabled, HOLD otherwise
        op(1, 8'h90, 1'b0);
        op(7, 8'h00, 1'b0);
`ifdef UNIV_SHIFT_REG_ASR_EN
        chk("mode7_out", out, 8'hC8);
`else
        chk("mode7_out", out, 8'h90);
`endif
        run_burst(7, 3, 1'b1);

        // Random single operations mixed with random bursts
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 2)
                run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b1);
            else
                op(int'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the burst count field.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mode  input  3  operation code (univ_shift_reg_pkg::mode_e).
REQ-006 in  input  WIDTH  parallel load data.
REQ-007 sin  input  1  serial input bit for SHL/SHR.
REQ-008 start  input  1  launches burst of count shifts using mode.
REQ-009 count  input  CNT_W  burst length (number of shifts).
REQ-010 out  output  WIDTH  register contents.
REQ-011 sout  output  1  last bit shifted/rotated out.
REQ-012 busy  output  1  burst in progress.
REQ-013 done  output  1  one-cycle pulse at burst completion.

Function
REQ-014 Modes: HOLD=0, LOAD=1, SHL=2, SHR=3, ROL=4, ROR=5, CLR=6; code 7 per REQ-032/033.
REQ-015 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE, start=0: mode applied once per clock, out updates on the next edge (1-cycle latency).
REQ-017 LOAD: out<=in; CLR: out<=0; HOLD: out unchanged.
REQ-018 SHL: out<={out[WIDTH-2:0],sin}, sout<=out[WIDTH-1]; SHR: out<={sin,out[WIDTH-1:1]}, sout<=out[0].
REQ-019 ROL/ROR rotate by one; sout<=bit that wrapped (old MSB for ROL, old LSB for ROR).
REQ-020 sout unchanged by HOLD, LOAD, CLR.
REQ-021 IDLE, start=1, mode in {SHL,SHR,ROL,ROR}, count>0: latch mode and count, go BUSY; first shift occurs on that same edge.
REQ-022 BUSY: one shift per clock using latched mode; sin sampled live each cycle; mode, in, start ignored.
REQ-023 Burst performs exactly min(count,WIDTH) shifts (count>WIDTH clamped), then enters DONE.
REQ-024 start=1 with count=0 or non-shift mode: no change to out, go DONE directly.
REQ-025 DONE lasts exactly one cycle (done=1), then IDLE; start in DONE ignored.
REQ-026 busy=1 in BUSY state only; done=1 in DONE state only.
REQ-027 Back-to-back bursts: a new start is accepted in the first IDLE cycle after DONE.

Reset
REQ-028 rst low asynchronously forces out=0, sout=0, busy=0, done=0, state IDLE, latched count=0.
REQ-029 Reset mid-burst aborts the burst with no done pulse.
REQ-030 Reset deassertion is synchronised externally; first operation occurs on first posedge with rst high.

Configuration
REQ-031 Macro UNIV_SHIFT_REG_ASR_EN selects arithmetic shift-right support.
REQ-032 With UNIV_SHIFT_REG_ASR_EN defined: mode 7 = ASR, out<={out[WIDTH-1],out[WIDTH-1:1]}, sout<=out[0]; legal in bursts.
REQ-033 Without it: mode 7 behaves as HOLD and, with start=1, as a non-shift mode (REQ-024).

Structure
REQ-034 Package univ_shift_reg_pkg holds mode_e enum, state_e enum, and the ASR code constant.
REQ-035 Single sub-module univ_shift_reg_core: combinational next-value/sout datapath from (mode, out, sin, in); FSM and counter stay in the top module.

Verification (WIDTH=8)
REQ-036 mode=LOAD, in=8'hA5 -> out=8'hA5 next cycle; then ROL one cycle -> out=8'h4B, sout=1.
REQ-037 out=8'h81, start=1, mode=SHR, count=3, sin=0 -> busy for 3 cycles, out=8'h10, sout=0, done pulses once.
REQ-038 out=8'h01, start=1, mode=ROL, count=15 -> clamped to 8 shifts, out=8'h01, done after 8 busy cycles.
REQ-039 start=1, count=0 -> out unchanged, busy never high, done=1 next cycle.
REQ-040 Burst SHL count=6, rst low after 2 shifts -> out=0, busy=0, no done pulse.
REQ-041 With UNIV_SHIFT_REG_ASR_EN, out=8'h90, mode=7 -> out=8'hC8; without it -> out=8'h90.
